// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the execute stage: ALU opcodes, forward selects
// and the operand-forwarding mux helper.
package riscv_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Reserved select 2'b11 falls back to the register-file value.
  function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                          input logic [31:0] rf_val,
                                          input logic [31:0] wb_val,
                                          input logic [31:0] mem_val);
    logic [31:0] res;
    case (sel)
      FWD_RF:  res = rf_val;
      FWD_WB:  res = wb_val;
      FWD_MEM: res = mem_val;
      default: res = rf_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/execute_cycle_alu.sv
// Purely combinational 32-bit ALU for the execute stage (module alu).
module alu
  import riscv_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUControl,
  output logic [31:0] Result,
  output logic        Zero
);

  logic [31:0] result_s;

  // Operation select; unassigned opcodes produce zero.
  always_comb begin
    result_s = 32'h0;
    case (ALUControl)
      ALU_ADD: result_s = A + B;
      ALU_SUB: result_s = A + ~B + 32'd1;
      ALU_AND: result_s = A & B;
      ALU_OR:  result_s = A | B;
      ALU_SLT: result_s = ($signed(A) < $signed(B)) ? 32'h1 : 32'h0;
      default: result_s = 32'h0;
    endcase
  end

  assign Result = result_s;
  assign Zero   = (result_s == 32'h0);

endmodule

// File: rtl/execute_cycle.sv
// RV32I execute stage: operand selection, ALU, branch decision/target and the
// EX/MEM pipeline register. Define FORWARDING_EN to add MEM/WB operand forwarding.
module execute_cycle
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        ALUSrcE,
  input  logic        BranchE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RD_E,
  input  logic [31:0] ResultW,
`ifdef FORWARDING_EN
  input  logic [1:0]  ForwardA_E,
  input  logic [1:0]  ForwardB_E,
`endif
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] PCPlus4M,
  output logic [31:0] WriteDataM,
  output logic [31:0] ALUResultM
);

  logic [31:0] src_a_s;
  logic [31:0] write_data_s;
  logic [31:0] src_b_s;
  logic [31:0] alu_result_s;
  logic        zero_s;

  logic        reg_write_r;
  logic        mem_write_r;
  logic        result_src_r;
  logic [4:0]  rd_r;
  logic [31:0] pc_plus4_r;
  logic [31:0] write_data_r;
  logic [31:0] alu_result_r;

`ifdef FORWARDING_EN
  // ALUResultM feedback comes from the EX/MEM register, so no combinational loop.
  always_comb begin
    src_a_s      = fwd_mux(ForwardA_E, RD1_E, ResultW, alu_result_r);
    write_data_s = fwd_mux(ForwardB_E, RD2_E, ResultW, alu_result_r);
  end
`else
  logic unused_resultw_s;
  assign unused_resultw_s = ^ResultW;

  // Without forwarding the register-file values pass straight through.
  always_comb begin
    src_a_s      = RD1_E;
    write_data_s = RD2_E;
  end
`endif

  // ALU B input: immediate or the (possibly forwarded) rs2 value.
  always_comb begin
    if (ALUSrcE) begin
      src_b_s = Imm_Ext_E;
    end else begin
      src_b_s = write_data_s;
    end
  end

  alu u_alu (
    .A          (src_a_s),
    .B          (src_b_s),
    .ALUControl (ALUControlE),
    .Result     (alu_result_s),
    .Zero       (zero_s)
  );

  assign PCSrcE    = BranchE & zero_s;
  assign PCTargetE = PCE + Imm_Ext_E;

  // EX/MEM pipeline register; no stall or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_r  <= 1'b0;
      mem_write_r  <= 1'b0;
      result_src_r <= 1'b0;
      rd_r         <= 5'd0;
      pc_plus4_r   <= 32'h0;
      write_data_r <= 32'h0;
      alu_result_r <= 32'h0;
    end else begin
      reg_write_r  <= RegWriteE;
      mem_write_r  <= MemWriteE;
      result_src_r <= ResultSrcE;
      rd_r         <= RD_E;
      pc_plus4_r   <= PCPlus4E;
      write_data_r <= write_data_s;
      alu_result_r <= alu_result_s;
    end
  end

  assign RegWriteM  = reg_write_r;
  assign MemWriteM  = mem_write_r;
  assign ResultSrcM = result_src_r;
  assign RD_M       = rd_r;
  assign PCPlus4M   = pc_plus4_r;
  assign WriteDataM = write_data_r;
  assign ALUResultM = alu_result_r;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed plan steps plus randomized
// instructions checked against a behavioural model.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALUResultM;

  int tests = 0;
  int fails = 0;
  logic [31:0] model_alum;

  always #5 clk = ~clk;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUSrcE(ALUSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ResultW(ResultW),
`ifdef FORWARDING_EN
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
`endif
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALUResultM(ALUResultM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 3'd0) return a + b;
    else if (op == 3'd1) return a - b;
    else if (op == 3'd2) return a & b;
    else if (op == 3'd3) return a | b;
    else if (op == 3'd5) return (sa < sb) ? 32'd1 : 32'd0;
    else return 32'd0;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf);
`ifdef FORWARDING_EN
    if (sel == 2'd1) return ResultW;
    if (sel == 2'd2) return model_alum;
`endif
    return rf;
  endfunction

  task automatic clear_inputs();
    RegWriteE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 1'b0; ALUSrcE = 1'b0;
    BranchE = 1'b0; ALUControlE = 3'd0; RD1_E = 32'd0; RD2_E = 32'd0;
    Imm_Ext_E = 32'd0; PCE = 32'd0; PCPlus4E = 32'd0; RD_E = 5'd0;
    ResultW = 32'd0; ForwardA_E = 2'd0; ForwardB_E = 2'd0;
  endtask

  // Inputs already applied; checks combinational outputs, clocks once, checks M outputs.
  task automatic step(input string tag);
    logic [31:0] a, wd, b, r, tgt;
    logic        taken, rw, mw, rs;
    logic [4:0]  rd;
    logic [31:0] pc4;
    #1;
    a   = ref_fwd(ForwardA_E, RD1_E);
    wd  = ref_fwd(ForwardB_E, RD2_E);
    b   = ALUSrcE ? Imm_Ext_E : wd;
    r   = ref_alu(ALUControlE, a, b);
    taken = BranchE && (r == 32'd0);
    tgt = PCE + Imm_Ext_E;
    rw = RegWriteE; mw = MemWriteE; rs = ResultSrcE; rd = RD_E; pc4 = PCPlus4E;
    chk({tag, ".PCSrcE"}, {31'd0, PCSrcE}, {31'd0, taken});
    chk({tag, ".PCTargetE"}, PCTargetE, tgt);
    @(posedge clk);
    #1;
    model_alum = r;
    chk({tag, ".RegWriteM"}, {31'd0, RegWriteM}, {31'd0, rw});
    chk({tag, ".MemWriteM"}, {31'd0, MemWriteM}, {31'd0, mw});
    chk({tag, ".ResultSrcM"}, {31'd0, ResultSrcM}, {31'd0, rs});
    chk({tag, ".RD_M"}, {27'd0, RD_M}, {27'd0, rd});
    chk({tag, ".PCPlus4M"}, PCPlus4M, pc4);
    chk({tag, ".WriteDataM"}, WriteDataM, wd);
    chk({tag, ".ALUResultM"}, ALUResultM, r);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".RegWriteM"}, {31'd0, RegWriteM}, 32'd0);
    chk({tag, ".MemWriteM"}, {31'd0, MemWriteM}, 32'd0);
    chk({tag, ".ResultSrcM"}, {31'd0, ResultSrcM}, 32'd0);
    chk({tag, ".RD_M"}, {27'd0, RD_M}, 32'd0);
    chk({tag, ".PCPlus4M"}, PCPlus4M, 32'd0);
    chk({tag, ".WriteDataM"}, WriteDataM, 32'd0);
    chk({tag, ".ALUResultM"}, ALUResultM, 32'd0);
  endtask

  initial begin
    model_alum = 32'd0;
    clear_inputs();
    rst = 1'b0;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ADD 5 + 7 -> x3
    clear_inputs();
    RD1_E = 32'd5; RD2_E = 32'd7; RD_E = 5'd3; RegWriteE = 1'b1; PCPlus4E = 32'h104;
    step("add");
    chk("add.const", ALUResultM, 32'd12);

    // BEQ taken, backwards target
    clear_inputs();
    BranchE = 1'b1; ALUControlE = 3'd1; RD1_E = 32'h10; RD2_E = 32'h10;
    PCE = 32'h100; Imm_Ext_E = 32'hFFFF_FFF8;
    #1;
    chk("beq.taken_const", {31'd0, PCSrcE}, 32'd1);
    chk("beq.target_const", PCTargetE, 32'hF8);
    step("beq_taken");
    RD2_E = 32'h11;
    step("beq_not_taken");

    // SLT signed both directions
    clear_inputs();
    ALUControlE = 3'd5; RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1;
    step("slt_neg");
    chk("slt_neg.const", ALUResultM, 32'd1);
    RD1_E = 32'd1; RD2_E = 32'hFFFF_FFFF;
    step("slt_pos");
    chk("slt_pos.const", ALUResultM, 32'd0);

    // Wrap and concurrent branch decision on an equal-operand SUB
    clear_inputs();
    RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1;
    step("wrap_add");
    chk("wrap_add.const", ALUResultM, 32'd0);
    ALUControlE = 3'd1; BranchE = 1'b1; RD2_E = 32'hFFFF_FFFF;
    step("wrap_beq");

`ifdef FORWARDING_EN
    // MEM forward: previous result 0x20
    clear_inputs();
    RD1_E = 32'h1F; RD2_E = 32'h1;
    step("fwd_prep");
    RD1_E = 32'd0; ForwardA_E = 2'b10;
    step("fwd_mem");
    chk("fwd_mem.const", ALUResultM, 32'h21);
    clear_inputs();
    ResultW = 32'd9; ForwardB_E = 2'b01; MemWriteE = 1'b1; ALUSrcE = 1'b1;
    RD2_E = 32'h55; Imm_Ext_E = 32'd4;
    step("fwd_wb");
    chk("fwd_wb.const", WriteDataM, 32'd9);
`endif

    // Asynchronous reset between edges, then normal capture
    clear_inputs();
    RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 1'b1; RD_E = 5'd31;
    RD1_E = 32'h1234; RD2_E = 32'h5678; PCPlus4E = 32'hABC;
    step("preload");
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    model_alum = 32'd0;
    #2;
    rst = 1'b1;
    step("post_reset");

    // Randomized instructions
    for (int i = 0; i < 60; i++) begin
      RegWriteE   = 1'($urandom_range(0, 1));
      MemWriteE   = 1'($urandom_range(0, 1));
      ResultSrcE  = 1'($urandom_range(0, 1));
      ALUSrcE     = 1'($urandom_range(0, 1));
      BranchE     = 1'($urandom_range(0, 1));
      ALUControlE = 3'($urandom_range(0, 7));
      RD1_E       = $urandom;
      RD2_E       = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
      Imm_Ext_E   = $urandom;
      PCE         = $urandom;
      PCPlus4E    = PCE + 32'd4;
      RD_E        = 5'($urandom_range(0, 31));
      ResultW     = $urandom;
      ForwardA_E  = 2'($urandom_range(0, 3));
      ForwardB_E  = 2'($urandom_range(0, 3));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
